// File: rtl/sample_mixer_gen.sv
// N-voice sample mixer: fetches 8-bit samples per channel over a shared DMA read
// port and mixes the active voices into one saturated 16-bit sample per freq tick.
module sample_mixer_gen #(
  parameter int CHANNELS  = 4,
  parameter int ADDR_W    = 16,
  parameter int FRAC_BITS = 8,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freq,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              cfg_loop,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [15:0]       cfg_speed,
  input  logic [7:0]        cfg_vol,
  output logic [ADDR_W-1:0] dma_addr,
  output logic              dma_start,
  input  logic [15:0]       dma_data,
  input  logic              dma_rdy,
  output logic [15:0]       out,
  output logic              start,
  output logic              busy,
  output logic              overrun
);

  localparam int POS_W = ADDR_W + 1 + FRAC_BITS;
  localparam int ACC_W = 16 + CH_W;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, EMIT} state_t;

  state_t           state_reg;
  logic [CH_W-1:0]  ch_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             any_reg;

  logic [POS_W-1:0]    pos_w       [CHANNELS];
  logic [POS_W-1:0]    start_pos_w [CHANNELS];
  logic [15:0]         speed_w     [CHANNELS];
  logic [7:0]          vol_w       [CHANNELS];
  logic [CHANNELS-1:0] active_w;
  logic [CHANNELS-1:0] loop_w;

  logic [POS_W-1:0] cur_pos;
  logic [7:0]       cur_byte;
  logic [15:0]      cur_prod;
  logic             eng_upd;
  logic [POS_W-1:0] eng_pos_next;
  logic             eng_active_next;
  logic             last_ch;

  // Position update the engine proposes for the channel whose read just returned.
  always_comb begin
    cur_pos         = pos_w[ch_reg];
    cur_byte        = cur_pos[FRAC_BITS] ? dma_data[15:8] : dma_data[7:0];
    cur_prod        = 16'(cur_byte) * 16'(vol_w[ch_reg]);
    eng_upd         = (state_reg == WAIT) && dma_rdy;
    eng_pos_next    = cur_pos + POS_W'(speed_w[ch_reg]);
    eng_active_next = 1'b1;
    if (cur_byte == 8'hFF) begin
      if (loop_w[ch_reg]) begin
        eng_pos_next = start_pos_w[ch_reg];
      end else begin
        eng_pos_next    = cur_pos;
        eng_active_next = 1'b0;
      end
    end
  end

  assign last_ch = (ch_reg == CH_W'(CHANNELS - 1));
  assign busy    = (state_reg != IDLE);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [POS_W-1:0] pos_reg;
      logic [POS_W-1:0] start_pos_reg;
      logic [15:0]      speed_reg;
      logic [7:0]       vol_reg;
      logic             active_reg;
      logic             loop_reg;
      logic             cfg_hit;
      logic             eng_hit;

      assign cfg_hit = (cfg_ch == CH_W'(gi)) && (cfg_start || cfg_stop || cfg_loop);
      assign eng_hit = eng_upd && (ch_reg == CH_W'(gi));

      // Any config strobe to this channel takes priority over the engine's update.
      always_ff @(posedge clk) begin
        if (!rst) begin
          pos_reg       <= '0;
          start_pos_reg <= '0;
          speed_reg     <= '0;
          vol_reg       <= '0;
          active_reg    <= 1'b0;
          loop_reg      <= 1'b0;
        end else if (cfg_hit) begin
          if (cfg_start) begin
            speed_reg  <= cfg_speed;
            vol_reg    <= cfg_vol;
            active_reg <= (cfg_speed != 16'd0);
            if (cfg_addr != '0) begin
              pos_reg       <= {cfg_addr, 1'b0, {FRAC_BITS{1'b0}}};
              start_pos_reg <= {cfg_addr, 1'b0, {FRAC_BITS{1'b0}}};
              loop_reg      <= 1'b0;
            end
          end
          if (cfg_stop) begin
            active_reg <= 1'b0;
            pos_reg    <= '0;
          end
          if (cfg_loop) begin
            loop_reg <= 1'b1;
          end
        end else if (eng_hit) begin
          pos_reg    <= eng_pos_next;
          active_reg <= eng_active_next;
        end
      end

      assign pos_w[gi]       = pos_reg;
      assign start_pos_w[gi] = start_pos_reg;
      assign speed_w[gi]     = speed_reg;
      assign vol_w[gi]       = vol_reg;
      assign active_w[gi]    = active_reg;
      assign loop_w[gi]      = loop_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
      acc_reg   <= '0;
      any_reg   <= 1'b0;
      dma_addr  <= '0;
      dma_start <= 1'b0;
      out       <= '0;
      start     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      dma_start <= 1'b0;
      start     <= 1'b0;
      overrun   <= freq && (state_reg != IDLE);
      case (state_reg)
        IDLE: begin
          if (freq) begin
            acc_reg   <= '0;
            any_reg   <= 1'b0;
            ch_reg    <= '0;
            state_reg <= REQ;
          end
        end
        REQ: begin
          if (active_w[ch_reg]) begin
            dma_start <= 1'b1;
            dma_addr  <= cur_pos[POS_W-1 -: ADDR_W];
            state_reg <= WAIT;
          end else if (last_ch) begin
            state_reg <= EMIT;
          end else begin
            ch_reg <= ch_reg + 1'b1;
          end
        end
        WAIT: begin
          if (dma_rdy) begin
            if (cur_byte != 8'hFF) begin
              acc_reg <= acc_reg + ACC_W'(cur_prod);
              any_reg <= 1'b1;
            end
            if (last_ch) begin
              state_reg <= EMIT;
            end else begin
              ch_reg    <= ch_reg + 1'b1;
              state_reg <= REQ;
            end
          end
        end
        EMIT: begin
          if (any_reg) begin
            out   <= (|acc_reg[ACC_W-1:16]) ? 16'hFFFF : acc_reg[15:0];
            start <= 1'b1;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_mixer_gen.sv
// Scoreboard bench for sample_mixer_gen: a per-tick sample-level mixing model
// predicts DMA addresses and mixed outputs; a monitor checks what the DUT presents.
module tb_sample_mixer_gen;
  localparam int CHANNELS  = 4;
  localparam int ADDR_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int CH_W      = 2;
  localparam int POS_MOD   = 1 << (ADDR_W + 1 + FRAC_BITS);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              freq = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic              cfg_start = 1'b0;
  logic              cfg_stop = 1'b0;
  logic              cfg_loop = 1'b0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [15:0]       cfg_speed = '0;
  logic [7:0]        cfg_vol = '0;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_start;
  logic [15:0]       dma_data = '0;
  logic              dma_rdy = 1'b0;
  logic [15:0]       mix_out;
  logic              start;
  logic              busy;
  logic              overrun;

  always #5 clk = ~clk;

  sample_mixer_gen #(.CHANNELS(CHANNELS), .ADDR_W(ADDR_W), .FRAC_BITS(FRAC_BITS)) dut (
    .clk(clk), .rst(rst), .freq(freq), .cfg_ch(cfg_ch), .cfg_start(cfg_start),
    .cfg_stop(cfg_stop), .cfg_loop(cfg_loop), .cfg_addr(cfg_addr), .cfg_speed(cfg_speed),
    .cfg_vol(cfg_vol), .dma_addr(dma_addr), .dma_start(dma_start), .dma_data(dma_data),
    .dma_rdy(dma_rdy), .out(mix_out), .start(start), .busy(busy), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;
  int exp_out_q[$];
  int exp_addr_q[$];
  logic [15:0] mem [int];
  int rdy_delay = 0;
  bit rand_delay = 1'b0;
  bit mem_manual = 1'b0;

  // Reference state: positions counted in 1/256ths of a byte-sample.
  bit m_active [CHANNELS];
  int m_pos    [CHANNELS];
  int m_start  [CHANNELS];
  int m_speed  [CHANNELS];
  int m_vol    [CHANNELS];
  bit m_loop   [CHANNELS];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int rd_word(int w);
    return mem.exists(w) ? int'(mem[w]) : 0;
  endfunction

  function automatic int sample_at(int p);
    int b;
    int w;
    b = p >> FRAC_BITS;
    w = rd_word(b >> 1);
    return ((b & 1) == 1) ? ((w >> 8) & 255) : (w & 255);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      m_active[c] = 1'b0; m_pos[c] = 0; m_start[c] = 0;
      m_speed[c] = 0; m_vol[c] = 0; m_loop[c] = 1'b0;
    end
  endfunction

  function automatic void model_cfg(int ch, bit st, bit sp, bit lp, int addr, int speed, int vol);
    if (st) begin
      m_speed[ch] = speed; m_vol[ch] = vol; m_active[ch] = (speed != 0);
      if (addr != 0) begin
        m_pos[ch] = addr * 512; m_start[ch] = addr * 512; m_loop[ch] = 1'b0;
      end
    end
    if (sp) begin m_active[ch] = 1'b0; m_pos[ch] = 0; end
    if (lp) m_loop[ch] = 1'b1;
  endfunction

  // One freq tick: each active voice reads one sample; the sum saturates at 16 bits.
  function automatic void model_tick();
    int sum;
    bit any;
    int s;
    sum = 0; any = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (m_active[c]) begin
        exp_addr_q.push_back(m_pos[c] >> (FRAC_BITS + 1));
        s = sample_at(m_pos[c]);
        if (s != 255) begin
          sum += s * m_vol[c]; any = 1'b1;
          m_pos[c] = (m_pos[c] + m_speed[c]) % POS_MOD;
        end else if (m_loop[c]) m_pos[c] = m_start[c];
        else m_active[c] = 1'b0;
      end
    end
    if (any) exp_out_q.push_back(sum > 65535 ? 65535 : sum);
  endfunction

  task automatic do_cfg(int ch, bit st, bit sp, bit lp, int addr, int speed, int vol);
    cfg_ch = CH_W'(ch); cfg_start = st; cfg_stop = sp; cfg_loop = lp;
    cfg_addr = ADDR_W'(addr); cfg_speed = 16'(speed); cfg_vol = 8'(vol);
    @(negedge clk);
    cfg_start = 1'b0; cfg_stop = 1'b0; cfg_loop = 1'b0;
    model_cfg(ch, st, sp, lp, addr, speed, vol);
  endtask

  task automatic stop_all();
    for (int c = 0; c < CHANNELS; c++) do_cfg(c, 1'b0, 1'b1, 1'b0, 0, 0, 0);
  endtask

  // Waits for the engine to go idle; lat = negedges after freq until start, -1 if none.
  task automatic wait_idle(output int lat);
    int cnt;
    cnt = 1; lat = -1;
    while (busy && cnt < 1000) begin
      @(negedge clk); cnt++;
      if (start && lat < 0) lat = cnt;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL tick_timeout: busy still 1 after %0d cycles, expected 0", cnt);
    end
  endtask

  task automatic tick(output int lat);
    model_tick();
    freq = 1'b1; @(negedge clk); freq = 1'b0;
    check("overrun_idle", int'(overrun), 0);
    wait_idle(lat);
  endtask

  // Memory responder: answers each request after a programmable delay.
  initial begin
    int a;
    int d;
    forever begin
      @(negedge clk);
      if (dma_start && !mem_manual) begin
        a = int'(dma_addr);
        d = rand_delay ? int'($urandom_range(0, 3)) : rdy_delay;
        repeat (d) @(negedge clk);
        dma_data = 16'(rd_word(a)); dma_rdy = 1'b1;
        @(negedge clk);
        dma_rdy = 1'b0;
      end
    end
  end

  // Monitor: every DUT output event pops and compares one scoreboard entry.
  always @(negedge clk) begin
    if (rst) begin
      if (start) begin
        if (exp_out_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: start with out=0x%0h, expected no start", mix_out);
        end else check("out", int'(mix_out), exp_out_q.pop_front());
      end
      if (dma_start) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL dma_unexpected: dma_start addr=0x%0h, expected no request", dma_addr);
        end else check("dma_addr", int'(dma_addr), exp_addr_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int op;
    int ch;
    int spd_tab[6];
    spd_tab = '{0, 'h40, 'h80, 'h100, 'h180, 'h300};
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_out", int'(mix_out), 0);
    check("rst_start", int'(start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_dma_start", int'(dma_start), 0);
    check("rst_dma_addr", int'(dma_addr), 0);
    check("rst_overrun", int'(overrun), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single voice, unity speed; start appears CHANNELS+3 negedges after freq.
    mem[32'h100] = 16'h2010;
    do_cfg(0, 1'b1, 1'b0, 1'b0, 'h100, 'h100, 255);
    tick(lat);
    check("latency", lat, CHANNELS + 3);
    tick(lat);

    // Half speed: each byte repeats on two ticks, word advances every 4 ticks.
    stop_all();
    mem[32'h700] = 16'h0201; mem[32'h701] = 16'h0403;
    do_cfg(0, 1'b1, 1'b0, 1'b0, 'h700, 'h80, 1);
    repeat (8) tick(lat);

    // End marker 0xFF without and with loop.
    stop_all();
    mem[32'h400] = 16'hFF33;
    do_cfg(0, 1'b1, 1'b0, 1'b0, 'h400, 'h100, 2);
    repeat (3) tick(lat);
    check("ff_noloop_nostart", lat, -1);
    do_cfg(0, 1'b1, 1'b0, 1'b0, 'h400, 'h100, 2);
    do_cfg(0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    repeat (5) tick(lat);

    // Four voices of 0xFE at full volume saturate the mix.
    stop_all();
    for (int c = 0; c < CHANNELS; c++) begin
      mem['h500 + c] = 16'hFEFE;
      do_cfg(c, 1'b1, 1'b0, 1'b0, 'h500 + c, 'h100, 255);
    end
    tick(lat);
    check("saturate_start_seen", int'(lat > 0), 1);

    // freq while waiting on DMA: overrun pulse, still one output.
    stop_all();
    mem[32'h480] = 16'h0011;
    do_cfg(0, 1'b1, 1'b0, 1'b0, 'h480, 'h100, 3);
    rdy_delay = 4;
    model_tick();
    freq = 1'b1; @(negedge clk); freq = 1'b0;
    @(negedge clk);
    freq = 1'b1; @(negedge clk);
    check("overrun_pulse", int'(overrun), 1);
    freq = 1'b0;
    wait_idle(lat);
    check("overrun_clear", int'(overrun), 0);
    rdy_delay = 0;

    // Random voices, configs and DMA latencies.
    stop_all();
    for (int i = 0; i < 16; i++) begin
      int lo;
      int hi;
      lo = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 254));
      hi = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 254));
      mem['h800 + i] = 16'((hi << 8) | lo);
    end
    rand_delay = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        op = int'($urandom_range(0, 5));
        ch = int'($urandom_range(0, CHANNELS - 1));
        if (op <= 3)
          do_cfg(ch, 1'b1, 1'b0, 1'b0, (op == 3) ? 0 : 'h800 + int'($urandom_range(0, 15)),
                 spd_tab[$urandom_range(0, 5)], int'($urandom_range(0, 255)));
        else if (op == 4) do_cfg(ch, 1'b0, 1'b1, 1'b0, 0, 0, 0);
        else do_cfg(ch, 1'b0, 1'b0, 1'b1, 0, 0, 0);
      end
      tick(lat);
    end
    rand_delay = 1'b0;

    // Reset in the middle of a DMA wait; the late read completion must be ignored.
    stop_all();
    mem[32'h200] = 16'h0005;
    do_cfg(0, 1'b1, 1'b0, 1'b0, 'h200, 'h100, 10);
    rdy_delay = 6;
    exp_addr_q.push_back('h200);
    freq = 1'b1; @(negedge clk); freq = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; @(negedge clk);
    check("midrst_out", int'(mix_out), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_dma_start", int'(dma_start), 0);
    check("midrst_dma_addr", int'(dma_addr), 0);
    rst = 1'b1;
    model_reset();
    repeat (12) @(negedge clk);
    check("midrst_idle_after_late_rdy", int'(busy), 0);
    rdy_delay = 0;
    tick(lat);
    check("midrst_no_voice", lat, -1);

    // Start and stop together leave the channel inactive.
    do_cfg(1, 1'b1, 1'b1, 1'b0, 'h600, 'h100, 50);
    tick(lat);
    check("start_stop_inactive", lat, -1);

    // Config on ch1 in the same cycle as its read completes: config wins.
    mem[32'h610] = 16'h0302; mem[32'h620] = 16'h0908;
    do_cfg(1, 1'b1, 1'b0, 1'b0, 'h610, 'h100, 4);
    mem_manual = 1'b1;
    model_tick();
    freq = 1'b1; @(negedge clk); freq = 1'b0;
    lat = 0;
    while (!dma_start && lat < 20) begin @(negedge clk); lat++; end
    check("manual_dma_seen", int'(dma_start), 1);
    dma_data = 16'h0302; dma_rdy = 1'b1;
    cfg_ch = 2'd1; cfg_start = 1'b1; cfg_addr = 16'h0620; cfg_speed = 16'h0200; cfg_vol = 8'd3;
    @(negedge clk);
    dma_rdy = 1'b0; cfg_start = 1'b0;
    model_cfg(1, 1'b1, 1'b0, 1'b0, 'h620, 'h200, 3);
    wait_idle(lat);
    mem_manual = 1'b0;
    repeat (2) tick(lat);

    @(negedge clk);
    check("out_queue_empty", exp_out_q.size(), 0);
    check("addr_queue_empty", exp_addr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
